majority_voter_win: RTL and testbench

MAJORITY_VOTER_WIN -- requirements
Module: majority_voter_win

---
 rtl/majority_voter_win.sv | 134 +++++++++++++
 tb/tb_majority_voter_win.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/majority_voter_win.sv
// Spatial vote over N channel bits, then a temporal majority over the last W votes.
// One-cycle latency; the window is a shift register with a running sum of ones.
module majority_voter_win #(
  parameter int unsigned N = 3,
  parameter int unsigned W = 8,
  localparam int unsigned CW = $clog2(N + 1),
  localparam int unsigned WW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [N-1:0]  in_bits,
  input  logic [1:0]    mode,
  input  logic [CW-1:0] thresh,
  output logic          out_valid,
  output logic          vote,
  output logic [CW-1:0] ones_cnt,
  output logic          win_vote,
  output logic [WW-1:0] win_cnt,
  output logic [WW-1:0] win_fill,
  output logic          win_full
);

  localparam logic [CW-1:0] HALF  = CW'(N / 2);
  localparam logic [CW-1:0] ALL   = CW'(N);
  localparam logic [WW-1:0] DEPTH = WW'(W);

  logic          r_out_valid;
  logic          r_vote;
  logic [CW-1:0] r_ones;
  logic          r_win_vote;
  logic [WW-1:0] r_win_cnt;
  logic [WW-1:0] r_win_fill;
  logic          r_win_full;
  logic [W-1:0]  r_shift;

  logic [CW-1:0] w_ones;
  logic          w_vote;
  logic [W-1:0]  w_base_shift;
  logic [WW-1:0] w_base_cnt;
  logic [WW-1:0] w_base_fill;
  logic          w_base_wv;
  logic [W-1:0]  w_shift_nx;
  logic [WW-1:0] w_cnt_nx;
  logic [WW-1:0] w_fill_nx;
  logic          w_wv_nx;

  // Popcount of the incoming sample.
  always_comb begin
    w_ones = '0;
    for (int i = 0; i < N; i++) begin
      w_ones = w_ones + CW'(in_bits[i]);
    end
  end

  // Spatial vote rule selected by mode.
  always_comb begin
    w_vote = 1'b0;
    case (mode)
      2'b00:   w_vote = (w_ones > HALF);
      2'b01:   w_vote = (w_ones == ALL);
      2'b10:   w_vote = (w_ones != '0);
      default: w_vote = (w_ones >= thresh);
    endcase
  end

  // Window update: clear flushes first, then an accepted sample is pushed.
  always_comb begin
    w_base_shift = clear ? '0   : r_shift;
    w_base_cnt   = clear ? '0   : r_win_cnt;
    w_base_fill  = clear ? '0   : r_win_fill;
    w_base_wv    = clear ? 1'b0 : r_win_vote;
    w_shift_nx   = w_base_shift;
    w_cnt_nx     = w_base_cnt;
    w_fill_nx    = w_base_fill;
    w_wv_nx      = w_base_wv;
    if (in_valid) begin
      w_shift_nx = {w_base_shift[W-2:0], w_vote};
      if (w_base_fill == DEPTH) begin
        // Full window: oldest entry sits at the top of the shift register.
        if (w_vote && !w_base_shift[W-1]) begin
          w_cnt_nx = w_base_cnt + WW'(1);
        end else if (!w_vote && w_base_shift[W-1]) begin
          w_cnt_nx = w_base_cnt - WW'(1);
        end
      end else begin
        w_fill_nx = w_base_fill + WW'(1);
        if (w_vote) begin
          w_cnt_nx = w_base_cnt + WW'(1);
        end
      end
      // Tie keeps the previous temporal vote.
      if ({w_cnt_nx, 1'b0} > {1'b0, w_fill_nx}) begin
        w_wv_nx = 1'b1;
      end else if ({w_cnt_nx, 1'b0} < {1'b0, w_fill_nx}) begin
        w_wv_nx = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_vote      <= 1'b0;
      r_ones      <= '0;
      r_win_vote  <= 1'b0;
      r_win_cnt   <= '0;
      r_win_fill  <= '0;
      r_win_full  <= 1'b0;
      r_shift     <= '0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_vote <= w_vote;
        r_ones <= w_ones;
      end
      r_shift    <= w_shift_nx;
      r_win_cnt  <= w_cnt_nx;
      r_win_fill <= w_fill_nx;
      r_win_vote <= w_wv_nx;
      r_win_full <= (w_fill_nx == DEPTH);
    end
  end

  assign out_valid = r_out_valid;
  assign vote      = r_vote;
  assign ones_cnt  = r_ones;
  assign win_vote  = r_win_vote;
  assign win_cnt   = r_win_cnt;
  assign win_fill  = r_win_fill;
  assign win_full  = r_win_full;

endmodule

// File: tb/tb_majority_voter_win.sv
// Bench for majority_voter_win: directed cases on small instances and a
// randomized soak on N=7/W=16 compared against a queue-based reference model.
module tb_majority_voter_win;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instance A: N=3, W=4
  logic       a_reset, a_clear, a_in_valid;
  logic [2:0] a_in_bits;
  logic [1:0] a_mode;
  logic [1:0] a_thresh;
  logic       a_out_valid, a_vote, a_win_vote, a_win_full;
  logic [1:0] a_ones_cnt;
  logic [2:0] a_win_cnt, a_win_fill;

  majority_voter_win #(.N(3), .W(4)) u_a (
    .clk(clk), .reset(a_reset), .clear(a_clear), .in_valid(a_in_valid),
    .in_bits(a_in_bits), .mode(a_mode), .thresh(a_thresh),
    .out_valid(a_out_valid), .vote(a_vote), .ones_cnt(a_ones_cnt),
    .win_vote(a_win_vote), .win_cnt(a_win_cnt), .win_fill(a_win_fill),
    .win_full(a_win_full)
  );

  // Instance B: N=5, W=8
  logic       rst;
  logic       b_clear, b_in_valid;
  logic [4:0] b_in_bits;
  logic [1:0] b_mode;
  logic [2:0] b_thresh;
  logic       b_out_valid, b_vote, b_win_vote, b_win_full;
  logic [2:0] b_ones_cnt;
  logic [3:0] b_win_cnt, b_win_fill;

  majority_voter_win #(.N(5), .W(8)) u_b (
    .clk(clk), .reset(rst), .clear(b_clear), .in_valid(b_in_valid),
    .in_bits(b_in_bits), .mode(b_mode), .thresh(b_thresh),
    .out_valid(b_out_valid), .vote(b_vote), .ones_cnt(b_ones_cnt),
    .win_vote(b_win_vote), .win_cnt(b_win_cnt), .win_fill(b_win_fill),
    .win_full(b_win_full)
  );

  // Instance C: N=7, W=16
  logic       c_clear, c_in_valid;
  logic [6:0] c_in_bits;
  logic [1:0] c_mode;
  logic [2:0] c_thresh;
  logic       c_out_valid, c_vote, c_win_vote, c_win_full;
  logic [2:0] c_ones_cnt;
  logic [4:0] c_win_cnt, c_win_fill;

  majority_voter_win #(.N(7), .W(16)) u_c (
    .clk(clk), .reset(rst), .clear(c_clear), .in_valid(c_in_valid),
    .in_bits(c_in_bits), .mode(c_mode), .thresh(c_thresh),
    .out_valid(c_out_valid), .vote(c_vote), .ones_cnt(c_ones_cnt),
    .win_vote(c_win_vote), .win_cnt(c_win_cnt), .win_fill(c_win_fill),
    .win_full(c_win_full)
  );

  task automatic check_a_zero(input string pfx);
    check({pfx, "_ov"},   a_out_valid, 0);
    check({pfx, "_vote"}, a_vote, 0);
    check({pfx, "_ones"}, a_ones_cnt, 0);
    check({pfx, "_wv"},   a_win_vote, 0);
    check({pfx, "_wcnt"}, a_win_cnt, 0);
    check({pfx, "_fill"}, a_win_fill, 0);
    check({pfx, "_full"}, a_win_full, 0);
  endtask

  // Reference model state for instance C
  bit          mq[$];
  bit          m_wv, m_vote;
  int unsigned m_ones;

  function automatic bit rule(input int unsigned c, input int unsigned n,
                              input logic [1:0] md, input int unsigned th);
    case (md)
      2'b00:   return c > n / 2;
      2'b01:   return c == n;
      2'b10:   return c >= 1;
      default: return c >= th;
    endcase
  endfunction

  initial begin
    int exp_v[8] = '{0, 0, 0, 1, 0, 1, 1, 1};
    int exp_c[8] = '{0, 1, 1, 2, 1, 2, 2, 3};
    int unsigned th_tab[5]   = '{0, 0, 0, 4, 0};
    int unsigned vexp_tab[5] = '{1, 0, 1, 0, 1};
    int unsigned s;

    rst = 1'b1; a_reset = 1'b1;
    a_clear = 0; a_in_valid = 0; a_in_bits = '0; a_mode = 2'b00; a_thresh = '0;
    b_clear = 0; b_in_valid = 0; b_in_bits = '0; b_mode = 2'b00; b_thresh = '0;
    c_clear = 0; c_in_valid = 0; c_in_bits = '0; c_mode = 2'b00; c_thresh = '0;
    tick(); tick();
    check_a_zero("rst");
    check("rst_b_ov", b_out_valid, 0);
    check("rst_c_fill", c_win_fill, 0);
    rst = 1'b0; a_reset = 1'b0;

    // Exhaustive spatial majority on N=3
    for (int i = 0; i < 8; i++) begin
      a_in_valid = 1'b1; a_in_bits = 3'(i);
      tick();
      check($sformatf("exh_vote%0d", i), a_vote, exp_v[i]);
      check($sformatf("exh_ones%0d", i), a_ones_cnt, exp_c[i]);
      check($sformatf("exh_ov%0d", i), a_out_valid, 1);
    end

    // Clear alone flushes without out_valid
    a_in_valid = 1'b0; a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    check("clr_ov", a_out_valid, 0);
    check("clr_fill", a_win_fill, 0);
    check("clr_wcnt", a_win_cnt, 0);
    check("clr_wv", a_win_vote, 0);

    // Window fill 1,1,0,0 then eviction with 0
    foreach (exp_v[i]) if (i < 4) begin
      a_in_valid = 1'b1; a_in_bits = (i < 2) ? 3'b111 : 3'b000;
      tick();
    end
    check("fill4_fill", a_win_fill, 4);
    check("fill4_full", a_win_full, 1);
    check("fill4_wcnt", a_win_cnt, 2);
    check("fill4_wv_tie", a_win_vote, 1);
    a_in_bits = 3'b000;
    tick();
    check("evict_wcnt", a_win_cnt, 1);
    check("evict_wv", a_win_vote, 0);
    check("evict_fill", a_win_fill, 4);

    // Simultaneous clear and sample on a full window
    a_clear = 1'b1; a_in_bits = 3'b111;
    tick();
    a_clear = 1'b0;
    check("clrv_fill", a_win_fill, 1);
    check("clrv_wcnt", a_win_cnt, 1);
    check("clrv_wv", a_win_vote, 1);
    check("clrv_ov", a_out_valid, 1);
    check("clrv_full", a_win_full, 0);

    // Idle cycle: pulse drops, values hold
    a_in_valid = 1'b0;
    tick();
    check("idle_ov", a_out_valid, 0);
    check("idle_vote", a_vote, 1);
    check("idle_ones", a_ones_cnt, 3);
    check("idle_wv", a_win_vote, 1);

    // Reset mid-stream after 3 samples; sample during reset is dropped
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1; a_in_bits = 3'b111;
      tick();
    end
    a_reset = 1'b1;
    tick();
    check_a_zero("midrst");
    a_reset = 1'b0; a_in_bits = 3'b000;
    tick();
    check("postrst_fill", a_win_fill, 1);
    check("postrst_wcnt", a_win_cnt, 0);
    check("postrst_ov", a_out_valid, 1);
    a_in_valid = 1'b0;

    // Mode sweep on N=5 with c=3
    for (int i = 0; i < 5; i++) begin
      b_in_valid = 1'b1; b_in_bits = 5'b00111;
      b_mode = (i < 3) ? 2'(i) : 2'b11;
      b_thresh = 3'(th_tab[i]);
      tick();
      check($sformatf("mode_vote%0d", i), b_vote, vexp_tab[i]);
      check($sformatf("mode_ones%0d", i), b_ones_cnt, 3);
    end
    b_mode = 2'b11; b_thresh = 3'd6;
    tick();
    check("mode_th_gt_n", b_vote, 0);
    b_thresh = 3'd3;
    tick();
    check("mode_th_eq_c", b_vote, 1);
    b_in_valid = 1'b0;

    // Random soak on N=7, W=16
    m_wv = 0; m_vote = 0; m_ones = 0; mq.delete();
    for (int k = 0; k < 10000; k++) begin
      c_in_valid = ($urandom_range(0, 9) < 7);
      c_clear    = ($urandom_range(0, 19) == 0);
      c_mode     = 2'($urandom_range(0, 3));
      c_thresh   = 3'($urandom_range(0, 7));
      c_in_bits  = 7'($urandom);
      if (c_clear) begin
        mq.delete();
        m_wv = 0;
      end
      if (c_in_valid) begin
        m_ones = $countones(c_in_bits);
        m_vote = rule(m_ones, 7, c_mode, c_thresh);
        if (mq.size() == 16) void'(mq.pop_front());
        mq.push_back(m_vote);
        s = 0;
        foreach (mq[j]) s += mq[j];
        if (2 * s > mq.size()) m_wv = 1;
        else if (2 * s < mq.size()) m_wv = 0;
      end
      s = 0;
      foreach (mq[j]) s += mq[j];
      tick();
      check("soak_ov", c_out_valid, c_in_valid);
      check("soak_vote", c_vote, m_vote);
      check("soak_ones", c_ones_cnt, m_ones);
      check("soak_wv", c_win_vote, m_wv);
      check("soak_wcnt", c_win_cnt, s);
      check("soak_fill", c_win_fill, mq.size());
      check("soak_full", c_win_full, mq.size() == 16);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
